// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller for the digital clock.
// Conditions the four panel buttons, runs the hour/minute edit sequence,
// freezes and blinks the display while editing, and hands a BCD time to
// the clock counters with a one-cycle load pulse when the edit is committed.
module time_set_ctrl #(
    parameter int DEB_CYCLES   = 20000,
    parameter int BLINK_CYCLES = 2000000
) (
    input  logic       pCLK,
    input  logic       RST,
    input  logic [3:0] PSW,
    input  logic       fmt24,
    input  logic [3:0] cur_h10,
    input  logic [3:0] cur_h1,
    input  logic [3:0] cur_m10,
    input  logic [3:0] cur_m1,
    output logic       hold,
    output logic       load,
    output logic [3:0] ld_h10,
    output logic [3:0] ld_h1,
    output logic [3:0] ld_m10,
    output logic [3:0] ld_m1,
    output logic [3:0] blank
);

    localparam int DEB_W   = $clog2(DEB_CYCLES);
    localparam int BLINK_W = $clog2(BLINK_CYCLES);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {S_RUN, S_EDIT_H, S_EDIT_M, S_COMMIT} state_t;

    state_t           state;
    logic [3:0]       sync1, sync2;
    logic [3:0]       btn_sync;
    logic [3:0]       deb_lvl;
    logic [3:0]       press_ev;
    logic [DEB_W-1:0] deb_cnt [4];
    logic             ev_cancel, ev_mode, ev_up, ev_down;

    logic [3:0]         e_h10, e_h1, e_m10, e_m1;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_ph;

    logic [3:0] max_h10, max_h1;
    logic       edit_hour_ok, cur_hour_ok, cur_min_ok;
    logic [3:0] hu10, hu1, hd10, hd1, mu10, mu1, md10, md1;
    logic [3:0] blink_mask;

    // Two-flop synchroniser; reset to the released (high) raw level.
    always_ff @(posedge pCLK) begin
        if (RST) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= PSW;
            sync2 <= sync1;
        end
    end

    assign btn_sync = ~sync2;

    // Per-button debounce: accept a new level only after it has been stable long enough.
    always_ff @(posedge pCLK) begin
        if (RST) begin
            deb_lvl  <= '0;
            press_ev <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                press_ev[i] <= 1'b0;
                if (btn_sync[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_lvl[i]  <= btn_sync[i];
                    deb_cnt[i]  <= '0;
                    press_ev[i] <= btn_sync[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    assign ev_cancel = press_ev[3];
    assign ev_mode   = press_ev[0] & ~ev_cancel;
    assign ev_up     = press_ev[1] & ~press_ev[2] & ~ev_cancel & ~ev_mode;
    assign ev_down   = press_ev[2] & ~press_ev[1] & ~ev_cancel & ~ev_mode;

    // Range limits and BCD increment/decrement of the edited hour and minute.
    always_comb begin
        max_h10      = fmt24 ? 4'd2 : 4'd1;
        max_h1       = fmt24 ? 4'd3 : 4'd1;
        edit_hour_ok = (e_h1 <= 4'd9) && ({e_h10, e_h1} <= {max_h10, max_h1});
        cur_hour_ok  = (cur_h1 <= 4'd9) && ({cur_h10, cur_h1} <= {max_h10, max_h1});
        cur_min_ok   = (cur_m10 <= 4'd5) && (cur_m1 <= 4'd9);

        hu10 = e_h10;
        hu1  = e_h1 + 4'd1;
        if ({e_h10, e_h1} == {max_h10, max_h1}) begin
            hu10 = 4'd0;
            hu1  = 4'd0;
        end else if (e_h1 == 4'd9) begin
            hu10 = e_h10 + 4'd1;
            hu1  = 4'd0;
        end

        hd10 = e_h10;
        hd1  = e_h1 - 4'd1;
        if ({e_h10, e_h1} == 8'h00) begin
            hd10 = max_h10;
            hd1  = max_h1;
        end else if (e_h1 == 4'd0) begin
            hd10 = e_h10 - 4'd1;
            hd1  = 4'd9;
        end

        mu10 = e_m10;
        mu1  = e_m1 + 4'd1;
        if ({e_m10, e_m1} == 8'h59) begin
            mu10 = 4'd0;
            mu1  = 4'd0;
        end else if (e_m1 == 4'd9) begin
            mu10 = e_m10 + 4'd1;
            mu1  = 4'd0;
        end

        md10 = e_m10;
        md1  = e_m1 - 4'd1;
        if ({e_m10, e_m1} == 8'h00) begin
            md10 = 4'd5;
            md1  = 4'd9;
        end else if (e_m1 == 4'd0) begin
            md10 = e_m10 - 4'd1;
            md1  = 4'd9;
        end

        blink_mask = (state == S_EDIT_H) ? 4'b1100 : 4'b0011;
    end

    // Edit state machine with registered hold/load/blank and load values.
    always_ff @(posedge pCLK) begin
        if (RST) begin
            state     <= S_RUN;
            hold      <= 1'b0;
            load      <= 1'b0;
            blank     <= 4'b0000;
            ld_h10    <= '0;
            ld_h1     <= '0;
            ld_m10    <= '0;
            ld_m1     <= '0;
            e_h10     <= '0;
            e_h1      <= '0;
            e_m10     <= '0;
            e_m1      <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                S_RUN: begin
                    hold      <= 1'b0;
                    blank     <= 4'b0000;
                    blink_cnt <= '0;
                    blink_ph  <= 1'b0;
                    if (ev_mode) begin
                        e_h10 <= cur_hour_ok ? cur_h10 : 4'd0;
                        e_h1  <= cur_hour_ok ? cur_h1  : 4'd0;
                        e_m10 <= cur_min_ok  ? cur_m10 : 4'd0;
                        e_m1  <= cur_min_ok  ? cur_m1  : 4'd0;
                        hold  <= 1'b1;
                        state <= S_EDIT_H;
                    end
                end
                S_EDIT_H, S_EDIT_M: begin
                    if (!edit_hour_ok) begin
                        e_h10 <= 4'd0;
                        e_h1  <= 4'd0;
                    end
                    if (ev_cancel) begin
                        state     <= S_RUN;
                        hold      <= 1'b0;
                        blank     <= 4'b0000;
                        blink_cnt <= '0;
                        blink_ph  <= 1'b0;
                    end else if (ev_mode) begin
                        blank     <= 4'b0000;
                        blink_cnt <= '0;
                        blink_ph  <= 1'b0;
                        if (state == S_EDIT_H) begin
                            state <= S_EDIT_M;
                        end else begin
                            state  <= S_COMMIT;
                            load   <= 1'b1;
                            ld_h10 <= edit_hour_ok ? e_h10 : 4'd0;
                            ld_h1  <= edit_hour_ok ? e_h1  : 4'd0;
                            ld_m10 <= e_m10;
                            ld_m1  <= e_m1;
                        end
                    end else begin
                        if (state == S_EDIT_H && edit_hour_ok) begin
                            if (ev_up) begin
                                e_h10 <= hu10;
                                e_h1  <= hu1;
                            end else if (ev_down) begin
                                e_h10 <= hd10;
                                e_h1  <= hd1;
                            end
                        end
                        if (state == S_EDIT_M) begin
                            if (ev_up) begin
                                e_m10 <= mu10;
                                e_m1  <= mu1;
                            end else if (ev_down) begin
                                e_m10 <= md10;
                                e_m1  <= md1;
                            end
                        end
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= '0;
                            blink_ph  <= ~blink_ph;
                            blank     <= blink_ph ? 4'b0000 : blink_mask;
                        end else begin
                            blink_cnt <= blink_cnt + BLINK_W'(1);
                            blank     <= blink_ph ? blink_mask : 4'b0000;
                        end
                    end
                end
                S_COMMIT: begin
                    state <= S_RUN;
                    hold  <= 1'b0;
                    blank <= 4'b0000;
                end
                default: begin
                    state <= S_RUN;
                    hold  <= 1'b0;
                    blank <= 4'b0000;
                end
            endcase
        end
    end

endmodule
